sweep_job_scheduler: RTL and testbench
======================================

SWEEP_JOB_SCHEDULER -- requirements
Module: sweep_job_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, job queue entries (power of two, at least 2).
REQ-002 Parameter STOP_CYCLES, default 4, cycles that stop is held at end of job (at least 1).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 nrst  input  1  reset, asynchronous assert, active-low.
REQ-005 job_valid  input  1  job offer from host.
REQ-006 job_ready  output  1  queue can accept a job (high while not full).
REQ-007 job_prescaler  input  14  walker step period for the offered job.
REQ-008 job_sweeps  input  8  number of full GPIO sweeps for the offered job.
REQ-009 abort  input  1  one-cycle request to flush the queue and end the running job.
REQ-010 walk_done  input  1  done flag from the GPIO walker (high while last pin is lit).
REQ-011 walk_enable  output  1  walker enable.
REQ-012 walk_stop  output  1  walker stop.
REQ-013 walk_prescaler  output  14  walker prescaler.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 job_done  output  1  one-cycle pulse when a job completes normally.
REQ-016 job_aborted  output  1  one-cycle pulse when a running job is ended by abort.
REQ-017 sweep_count  output  8  completed sweeps of the current job.
REQ-018 queue_level  output  $clog2(FIFO_DEPTH)+1  jobs waiting in the queue.

Function
REQ-019 Handshake: a push occurs when job_valid and job_ready are both high; job_valid is ignored while full; push and pop in the same cycle leave queue_level unchanged.
REQ-020 FSM states: IDLE, LOAD, RUN, STOP, GAP.
REQ-021 IDLE: if queue_level is nonzero, go to LOAD; otherwise stay.
REQ-022 LOAD, one cycle: pop the head and latch prescaler and sweeps; clear sweep_count; go to RUN, or to GAP if sweeps is 0, with job_done pulsed in GAP.
REQ-023 RUN: walk_enable=1, walk_stop=0, walk_prescaler=latched value (stable for the whole job).
REQ-024 A rising edge of walk_done (registered compare) increments sweep_count; a level held high counts once.
REQ-025 RUN goes to STOP in the cycle after sweep_count equals the latched sweeps.
REQ-026 STOP: walk_enable=1, walk_stop=1 for exactly STOP_CYCLES cycles, then go to GAP; walk_done edges are ignored in STOP.
REQ-027 GAP, one cycle: walk_enable=0, walk_stop=0; job_done or job_aborted pulses here; go to IDLE.
REQ-028 Abort in LOAD or RUN: flush the queue in the same cycle (a push in that cycle is dropped), go to STOP, and pulse job_aborted instead of job_done in GAP.
REQ-029 Abort in IDLE, STOP or GAP: flush the queue only; the state sequence is unchanged.
REQ-030 sweep_count saturates at 255 and holds its value after a job until the next LOAD.
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH; order is strictly first-in first-out.

Reset
REQ-032 Asserting nrst (asynchronous) forces IDLE and empties the queue.
REQ-033 During reset, walk_enable, walk_stop, walk_prescaler, busy, job_done, job_aborted, sweep_count and queue_level are all 0, and job_ready is 1.
REQ-034 Reset mid-job abandons it without a job_done or job_aborted pulse.

Structure
REQ-035 A shared package sweep_sched_pkg holds the state enum type and the widths PRESCALER_W=14 and SWEEPS_W=8.
REQ-036 Instantiate one sub-module, sweep_job_fifo (parameterized synchronous FIFO with full/empty/level).
REQ-037 The FSM, edge detector and counters are local to the top.

Verification
REQ-038 Reset: after reset, all outputs as in REQ-033, and a job push is accepted in the first cycle.
REQ-039 Single job {prescaler=1, sweeps=2} with three walk_done pulses:
  - walk_prescaler=1 and walk_enable=1 two cycles after the push;
  - sweep_count=2, then STOP for 4 cycles, GAP, one job_done pulse;
  - the third pulse is not counted.
REQ-040 Queue full: push 5 jobs back-to-back; the 5th stalls with job_ready=0, queue_level=4; all jobs run in order of their prescalers 1, 2, 3, 4, then the 5th.
REQ-041 Abort in RUN after 1 of 3 sweeps with 2 queued:
  - queue_level goes to 0 the next cycle;
  - walk_stop is held 4 cycles;
  - one job_aborted pulse, no job_done;
  - busy=0 afterwards.
REQ-042 Job with sweeps=0: LOAD, then GAP; job_done pulses with walk_enable never asserted.
REQ-043 Asynchronous reset asserted mid-RUN (between clock edges): outputs go to reset values immediately, and there is no pulse after reset is released.

Source files
------------

// File: rtl/sweep_sched_pkg.sv
// Shared types and widths for the sweep job scheduler and its job queue.
package sweep_sched_pkg;

    localparam int PRESCALER_W = 14;
    localparam int SWEEPS_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_STOP,
        ST_GAP
    } state_t;

    // One queued job as it is stored in the FIFO.
    typedef struct packed {
        logic [PRESCALER_W-1:0] prescaler;
        logic [SWEEPS_W-1:0]    sweeps;
    } job_t;

endpackage

// File: rtl/sweep_job_fifo.sv
// Synchronous FIFO holding pending jobs. It reports full, empty and an
// occupancy level. A flush empties it and drops any push in the same cycle.
module sweep_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (PTR_W+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // Write the offered job into the slot at the write pointer.
    // NOTE: the storage array has no reset; validity is defined only by the
    // pointers and level, so resetting the array would add logic for nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and level bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sweep_job_scheduler.sv
// Queues walker jobs from a host and runs them one at a time: enable the
// walker, count completed sweeps from walk_done rising edges, hold stop for a
// fixed number of cycles, then report done or aborted during a one-cycle gap.
module sweep_job_scheduler
    import sweep_sched_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int STOP_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [PRESCALER_W-1:0]       job_prescaler,
    input  logic [SWEEPS_W-1:0]          job_sweeps,
    input  logic                         abort,
    input  logic                         walk_done,
    output logic                         walk_enable,
    output logic                         walk_stop,
    output logic [PRESCALER_W-1:0]       walk_prescaler,
    output logic                         busy,
    output logic                         job_done,
    output logic                         job_aborted,
    output logic [SWEEPS_W-1:0]          sweep_count,
    output logic [$clog2(FIFO_DEPTH):0]  queue_level
);

    localparam int STOP_W = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;

    state_t                 state;
    state_t                 state_next;
    job_t                   job_in;
    job_t                   head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic [PRESCALER_W-1:0] prescaler_q;
    logic [SWEEPS_W-1:0]    sweeps_q;
    logic [SWEEPS_W-1:0]    sweep_count_q;
    logic                   walk_done_q;
    logic                   walk_rise;
    logic [STOP_W-1:0]      stop_cnt;
    logic                   aborted_q;

    assign job_in         = {job_prescaler, job_sweeps};
    assign job_ready      = !fifo_full;
    assign walk_rise      = walk_done && !walk_done_q;
    assign walk_prescaler = prescaler_q;
    assign sweep_count    = sweep_count_q;
    assign busy           = (state != ST_IDLE);

    // Abort doubles as the queue flush in every state.
    sweep_job_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(job_t))
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push    (job_valid),
        .pop     (pop),
        .flush   (abort),
        .wr_data (job_in),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (queue_level)
    );

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and Moore outputs.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        walk_enable = 1'b0;
        walk_stop   = 1'b0;
        job_done    = 1'b0;
        job_aborted = 1'b0;
        unique case (state)
            // An abort in IDLE flushes the queue, so do not start a load from it.
            ST_IDLE: if (!fifo_empty && !abort) state_next = ST_LOAD;
            ST_LOAD: begin
                pop = 1'b1;
                if (abort)                 state_next = ST_STOP;
                else if (head.sweeps == '0) state_next = ST_GAP;
                else                       state_next = ST_RUN;
            end
            ST_RUN: begin
                walk_enable = 1'b1;
                if (abort || sweep_count_q == sweeps_q) state_next = ST_STOP;
            end
            ST_STOP: begin
                walk_enable = 1'b1;
                walk_stop   = 1'b1;
                if (stop_cnt == STOP_W'(STOP_CYCLES - 1)) state_next = ST_GAP;
            end
            ST_GAP: begin
                job_done    = !aborted_q;
                job_aborted = aborted_q;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Job latch, walk_done edge detector, sweep counter and abort flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prescaler_q   <= '0;
            sweeps_q      <= '0;
            sweep_count_q <= '0;
            walk_done_q   <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            walk_done_q <= walk_done;
            if (state == ST_LOAD) begin
                prescaler_q   <= head.prescaler;
                sweeps_q      <= head.sweeps;
                sweep_count_q <= '0;
                aborted_q     <= abort;
            end else if (state == ST_RUN) begin
                if (abort) begin
                    aborted_q <= 1'b1;
                end else if (walk_rise && sweep_count_q != sweeps_q &&
                             sweep_count_q != '1) begin
                    sweep_count_q <= sweep_count_q + 1'b1;
                end
            end
        end
    end

    // Counts cycles spent in STOP; idles at zero elsewhere.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                 stop_cnt <= '0;
        else if (state == ST_STOP) stop_cnt <= stop_cnt + 1'b1;
        else                       stop_cnt <= '0;
    end

endmodule

// File: tb/tb_sweep_job_scheduler.sv
// Directed bench for sweep_job_scheduler. Stimulus pushes the expected job
// completion records into a scoreboard; a monitor compares them against each
// job_done / job_aborted pulse.
module tb_sweep_job_scheduler;

    logic        tb_clk;
    logic        nrst;
    logic        job_valid;
    logic        job_ready;
    logic [13:0] job_prescaler;
    logic [7:0]  job_sweeps;
    logic        abort;
    logic        walk_done;
    logic        walk_enable;
    logic        walk_stop;
    logic [13:0] walk_prescaler;
    logic        busy;
    logic        job_done;
    logic        job_aborted;
    logic [7:0]  sweep_count;
    logic [2:0]  queue_level;

    typedef struct {
        logic [1:0]  kind;      // {job_done, job_aborted}
        logic [13:0] presc;
        logic [7:0]  count;
        int          stop_len;
        bit          en_seen;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    sweep_job_scheduler #(
        .FIFO_DEPTH  (4),
        .STOP_CYCLES (4)
    ) dut (
        .clk            (tb_clk),
        .nrst           (nrst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_prescaler  (job_prescaler),
        .job_sweeps     (job_sweeps),
        .abort          (abort),
        .walk_done      (walk_done),
        .walk_enable    (walk_enable),
        .walk_stop      (walk_stop),
        .walk_prescaler (walk_prescaler),
        .busy           (busy),
        .job_done       (job_done),
        .job_aborted    (job_aborted),
        .sweep_count    (sweep_count),
        .queue_level    (queue_level)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic expect_job(input logic [1:0] kind, input logic [13:0] presc,
                              input logic [7:0] count, input int stop_len, input bit en_seen);
        exp_t e;
        e.kind = kind; e.presc = presc; e.count = count;
        e.stop_len = stop_len; e.en_seen = en_seen;
        sb.push_back(e);
    endtask

    // Walker model: toggle walk_done while running so each sweep is a clean
    // rising edge, until the scheduler is idle with an empty queue.
    task automatic drain(input int budget);
        int n = 0;
        while ((busy || queue_level != 0) && n < budget) begin
            walk_done = walk_enable && !walk_stop && !walk_done;
            tick();
            n++;
        end
        walk_done = 1'b0;
        check("drain_reaches_idle", {busy, queue_level}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_walk_enable"},    walk_enable, 0);
        check({tag, "_walk_stop"},      walk_stop, 0);
        check({tag, "_walk_prescaler"}, walk_prescaler, 0);
        check({tag, "_busy"},           busy, 0);
        check({tag, "_job_done"},       job_done, 0);
        check({tag, "_job_aborted"},    job_aborted, 0);
        check({tag, "_sweep_count"},    sweep_count, 0);
        check({tag, "_queue_level"},    queue_level, 0);
        check({tag, "_job_ready"},      job_ready, 1);
    endtask

    // Monitor: compare each completion pulse with the next scoreboard entry.
    initial begin
        int   stop_run = 0;
        bit   en_seen  = 1'b0;
        exp_t e;
        forever begin
            @(negedge tb_clk);
            if (!nrst) begin
                stop_run = 0;
                en_seen  = 1'b0;
            end else if (job_done || job_aborted) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {job_done, job_aborted}, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind",      {job_done, job_aborted}, e.kind);
                    check("pulse_prescaler", walk_prescaler, e.presc);
                    check("pulse_sweeps",    sweep_count, e.count);
                    check("stop_length",     stop_run, e.stop_len);
                    check("enable_seen",     en_seen, e.en_seen);
                    check("gap_walker_off",  {walk_enable, walk_stop}, 0);
                end
                stop_run = 0;
                en_seen  = 1'b0;
            end else begin
                stop_run = walk_stop ? stop_run + 1 : 0;
                if (walk_enable) en_seen = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        nrst = 1'b0; job_valid = 1'b0; job_prescaler = '0; job_sweeps = '0;
        abort = 1'b0; walk_done = 1'b0;

        // Reset values, during and just after reset.
        #12;
        check_reset_outputs("in_reset");
        @(posedge tb_clk); #1;
        nrst = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        // Single job {1,2}; three walk_done pulses, the third falls in STOP.
        job_valid = 1'b1; job_prescaler = 14'd1; job_sweeps = 8'd2;
        check("first_push_ready", job_ready, 1);
        expect_job(2'b10, 14'd1, 8'd2, 4, 1'b1);
        tick();
        job_valid = 1'b0;
        check("level_after_push", queue_level, 1);
        tick();
        check("load_busy", busy, 1);
        tick();
        check("run_enable_2cyc",    walk_enable, 1);
        check("run_prescaler_2cyc", walk_prescaler, 1);
        check("run_stop_low",       walk_stop, 0);
        check("run_level_popped",   queue_level, 0);
        walk_done = 1'b1; tick(); tick();
        walk_done = 1'b0; tick(); tick();
        check("held_level_counts_once", sweep_count, 1);
        walk_done = 1'b1; tick();
        walk_done = 1'b0; tick(); tick();
        check("second_sweep", sweep_count, 2);
        check("in_stop", walk_stop, 1);
        walk_done = 1'b1; tick();
        walk_done = 1'b0; tick();
        check("third_pulse_ignored", sweep_count, 2);
        drain(50);
        check("count_held_after_job", sweep_count, 2);

        // Job with zero sweeps: LOAD then GAP, walker never enabled.
        job_valid = 1'b1; job_prescaler = 14'd7; job_sweeps = 8'd0;
        expect_job(2'b10, 14'd7, 8'd0, 0, 1'b0);
        tick();
        job_valid = 1'b0;
        drain(50);

        // Queue full: a blocking job runs while jobs 1..4 fill the queue.
        job_valid = 1'b1; job_prescaler = 14'd100; job_sweeps = 8'd1;
        expect_job(2'b10, 14'd100, 8'd1, 4, 1'b1);
        tick();
        job_valid = 1'b0;
        tick(); tick();
        check("blocker_running", walk_enable, 1);
        for (int i = 1; i <= 4; i++) begin
            job_valid = 1'b1; job_prescaler = 14'(i); job_sweeps = 8'd1;
            expect_job(2'b10, 14'(i), 8'd1, 4, 1'b1);
            tick();
        end
        job_prescaler = 14'd5;
        check("full_ready_low", job_ready, 0);
        check("full_level_4",   queue_level, 4);
        tick(); tick();
        check("stall_ready_low", job_ready, 0);
        check("stall_level_4",   queue_level, 4);
        walk_done = 1'b1; tick();
        walk_done = 1'b0;
        begin
            int n = 0;
            while (!job_ready && n < 50) begin tick(); n++; end
        end
        check("fifth_push_ready", job_ready, 1);
        expect_job(2'b10, 14'd5, 8'd1, 4, 1'b1);
        tick();
        job_valid = 1'b0;
        drain(300);

        // Abort in RUN after 1 of 3 sweeps with 2 queued; push in abort cycle dropped.
        for (int i = 0; i < 3; i++) begin
            job_valid = 1'b1;
            job_prescaler = 14'(9 + i);
            job_sweeps = (i == 0) ? 8'd3 : 8'd1;
            tick();
        end
        job_valid = 1'b0;
        expect_job(2'b01, 14'd9, 8'd1, 4, 1'b1);
        check("abort_level_before", queue_level, 2);
        walk_done = 1'b1; tick();
        walk_done = 1'b0; tick();
        check("abort_one_sweep", sweep_count, 1);
        check("abort_still_run", walk_stop, 0);
        abort = 1'b1; job_valid = 1'b1; job_prescaler = 14'd12; job_sweeps = 8'd1;
        tick();
        abort = 1'b0; job_valid = 1'b0;
        check("abort_flushed", queue_level, 0);
        check("abort_stop",    walk_stop, 1);
        drain(50);
        check("abort_idle", busy, 0);

        // Asynchronous reset mid-RUN.
        job_valid = 1'b1; job_prescaler = 14'd13; job_sweeps = 8'd5;
        tick();
        job_valid = 1'b0;
        tick(); tick();
        walk_done = 1'b1; tick();
        walk_done = 1'b0; tick();
        check("pre_reset_running", {walk_enable, sweep_count}, {1'b1, 8'd1});
        #2 nrst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge tb_clk); #1;
        nrst = 1'b1;
        repeat (10) tick();
        check("after_reset_idle", busy, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
